controle_pilha: RTL and testbench
=================================

CONTROLE_PILHA -- requirements
Module: controle_pilha

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning the stack capacity mirrored by the internal occupancy counter.
REQ-002 The block SHALL have port clk  input  1  system clock, rising-edge active.
REQ-003 The block SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port cmd_valid  input  1  command request.
REQ-005 The block SHALL have port cmd_ready  output  1  controller can accept a command.
REQ-006 The block SHALL have port cmd_op  input  2  command code: 00 NOP, 01 PUSH, 10 POP, 11 EXEC.
REQ-007 The block SHALL have port cmd_data  input  8  PUSH immediate.
REQ-008 The block SHALL have port cmd_opcode  input  5  ALU opcode for EXEC.
REQ-009 The block SHALL have port push, pop and load, each output 1, strobes to the stack/ALU datapath.
REQ-010 The block SHALL have port din  output  8  data to the stack.
REQ-011 The block SHALL have port opcode  output  5  ALU opcode to the datapath.
REQ-012 The block SHALL have port s_ula  input  8  ALU result from the datapath.
REQ-013 The block SHALL have port carryout  input  1  ALU carry from the datapath.
REQ-014 The block SHALL have port outpilha  input  8  stack top data.
REQ-015 The block SHALL have port result  output  8  last captured value (s_ula for EXEC, outpilha for POP).
REQ-016 The block SHALL have port carry  output  1  captured carryout of the last EXEC.
REQ-017 The block SHALL have port done  output  1  one-cycle completion pulse.
REQ-018 The block SHALL have port err  output  1  one-cycle pulse, sticky-free, on a rejected command.
REQ-019 The block SHALL have port count  output  4  current stack occupancy.

Function
REQ-020 A command SHALL be accepted on a rising edge with cmd_valid=1 and cmd_ready=1; cmd_ready SHALL be 1 only in state IDLE.
REQ-021 On acceptance the block SHALL latch cmd_op, cmd_data and cmd_opcode; opcode SHALL hold the latched value until the next accepted EXEC.
REQ-022 States SHALL be IDLE, PUSH, POP1, LOAD1, GAP1, POP2, LOAD2, GAP2, WB, RD, RDCAP; each non-IDLE state SHALL last exactly one cycle.
REQ-023 NOP: no strobes; done SHALL pulse in the cycle after acceptance.
REQ-024 PUSH with count<DEPTH: push=1 and din=cmd_data for one cycle after acceptance, count+1, then IDLE with done=1.
REQ-025 PUSH with count=DEPTH: no push; err=1 and done=1 the cycle after acceptance; count unchanged.
REQ-026 POP with count>=1: the block SHALL enter RD with pop=1, then RDCAP; in RDCAP result<=outpilha and count-1; IDLE with done=1 follows.
REQ-027 POP with count=0: no pop; err=1 and done=1 the cycle after acceptance.
REQ-028 EXEC with count>=2: the strobe sequence SHALL be POP1(pop), LOAD1(load), GAP1(none), POP2(pop), LOAD2(load), GAP2(none), WB(push).
REQ-029 EXEC: at the end of GAP2 the block SHALL capture result<=s_ula and carry<=carryout; in WB din SHALL equal the captured result.
REQ-030 EXEC: count SHALL decrement by 2 across POP1/POP2 and increment by 1 in WB (net -1).
REQ-031 EXEC: done SHALL pulse in the IDLE cycle 8 cycles after acceptance.
REQ-032 EXEC with count<2: no strobes; err=1 and done=1 the cycle after acceptance.
REQ-033 At most one of push, pop and load SHALL be high in any cycle; all strobes SHALL be registered outputs.
REQ-034 cmd_valid while busy SHALL be ignored, with no effect on state.
REQ-035 The count arithmetic SHALL never wrap below 0 or above DEPTH.

Reset
REQ-036 rstn=0 SHALL immediately force state IDLE, push=pop=load=0, din=0, opcode=0, result=0, carry=0, done=0, err=0 and count=0.
REQ-037 After release, cmd_ready SHALL be 1 in the first cycle.
REQ-038 A reset in the middle of an operation SHALL abort it, with no done and no further strobes.

Verification
REQ-039 Sequence: reset, then PUSH 12, then PUSH 15 -> push pulses with din=12 and then din=15, count=2, and done after each.
REQ-040 Sequence: EXEC with opcode 00100, where the bench ALU model produces add giving 27 -> strobes pop, load, gap, pop, load, gap, push(din=27); result=27, carry=0, count=1, done 8 cycles after acceptance.
REQ-041 EXEC with count=1 -> err=1, done=1 with no strobes, count=1.
REQ-042 Sequence: fill to DEPTH=8, then PUSH 99 -> err=1, no push, count=8.
REQ-043 Sequence: count=0, then POP -> err=1; after one PUSH 7, POP -> result=7 and count=0.
REQ-044 Assert rstn=0 during LOAD1 of an EXEC -> all strobes 0 immediately, count=0, no done.

Source files
------------

// File: rtl/controle_pilha.sv
`default_nettype none
// ============================================================================
// Module      : controle_pilha
// Description : Command sequencer for a stack/ALU datapath. Accepts NOP,
//               PUSH, POP and EXEC commands through a valid/ready handshake,
//               then drives the push/pop/load strobes that move operands
//               between the stack and the ALU, tracking stack occupancy.
// Ports       : clk, rstn                  - clock, async active-low reset
//               cmd_valid/cmd_ready        - command handshake
//               cmd_op/cmd_data/cmd_opcode - command code, PUSH immediate,
//                                            ALU opcode
//               push/pop/load, din, opcode - registered datapath controls
//               s_ula, carryout, outpilha  - datapath results
//               result, carry              - last captured value / carry
//               done, err                  - one-cycle completion / reject
//               count                      - stack occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module controle_pilha #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_data,
   input  logic [4:0] cmd_opcode,
   output logic       push,
   output logic       pop,
   output logic       load,
   output logic [7:0] din,
   output logic [4:0] opcode,
   input  logic [7:0] s_ula,
   input  logic       carryout,
   input  logic [7:0] outpilha,
   output logic [7:0] result,
   output logic       carry,
   output logic       done,
   output logic       err,
   output logic [3:0] count
);

   localparam logic [3:0] c_DEPTH = 4'(DEPTH);

   localparam logic [1:0] c_OP_NOP  = 2'b00;
   localparam logic [1:0] c_OP_PUSH = 2'b01;
   localparam logic [1:0] c_OP_POP  = 2'b10;
   localparam logic [1:0] c_OP_EXEC = 2'b11;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_PUSH  = 4'd1,
      S_POP1  = 4'd2,
      S_LOAD1 = 4'd3,
      S_GAP1  = 4'd4,
      S_POP2  = 4'd5,
      S_LOAD2 = 4'd6,
      S_GAP2  = 4'd7,
      S_WB    = 4'd8,
      S_RD    = 4'd9,
      S_RDCAP = 4'd10
   } state_t;

   state_t r_state;
   state_t w_next;
   logic   w_accept;
   logic   w_done;
   logic   w_err;
   logic   w_push;
   logic   w_pop;
   logic   w_load;

   assign cmd_ready = (r_state == S_IDLE);
   assign w_accept  = cmd_valid && cmd_ready;

   always_comb begin
      w_next = r_state;
      w_done = 1'b0;
      w_err  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               case (cmd_op)
                  c_OP_NOP: w_done = 1'b1;
                  c_OP_PUSH: begin
                     if (count < c_DEPTH) w_next = S_PUSH;
                     else begin w_err = 1'b1; w_done = 1'b1; end
                  end
                  c_OP_POP: begin
                     if (count != 4'd0) w_next = S_RD;
                     else begin w_err = 1'b1; w_done = 1'b1; end
                  end
                  c_OP_EXEC: begin
                     if (count >= 4'd2) w_next = S_POP1;
                     else begin w_err = 1'b1; w_done = 1'b1; end
                  end
                  default: w_next = S_IDLE;
               endcase
            end
         end
         S_PUSH:  begin w_next = S_IDLE; w_done = 1'b1; end
         S_RD:    w_next = S_RDCAP;
         S_RDCAP: begin w_next = S_IDLE; w_done = 1'b1; end
         S_POP1:  w_next = S_LOAD1;
         S_LOAD1: w_next = S_GAP1;
         S_GAP1:  w_next = S_POP2;
         S_POP2:  w_next = S_LOAD2;
         S_LOAD2: w_next = S_GAP2;
         S_GAP2:  w_next = S_WB;
         S_WB:    begin w_next = S_IDLE; w_done = 1'b1; end
         default: w_next = S_IDLE;
      endcase
   end

   // Strobes are decoded from the next state and registered, so each strobe
   // is high exactly during the cycle spent in its state.
   assign w_push = (w_next == S_PUSH) || (w_next == S_WB);
   assign w_pop  = (w_next == S_POP1) || (w_next == S_POP2) || (w_next == S_RD);
   assign w_load = (w_next == S_LOAD1) || (w_next == S_LOAD2);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state <= S_IDLE;
         push    <= 1'b0;
         pop     <= 1'b0;
         load    <= 1'b0;
         din     <= 8'd0;
         opcode  <= 5'd0;
         result  <= 8'd0;
         carry   <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         count   <= 4'd0;
      end else begin
         r_state <= w_next;
         push    <= w_push;
         pop     <= w_pop;
         load    <= w_load;
         done    <= w_done;
         err     <= w_err;

         if (w_accept && (cmd_op == c_OP_EXEC)) opcode <= cmd_opcode;
         if ((r_state == S_IDLE) && (w_next == S_PUSH)) din <= cmd_data;

         // Both operands are loaded by the end of GAP2; the ALU result is
         // captured here and written back during WB.
         if (r_state == S_GAP2) begin
            result <= s_ula;
            carry  <= carryout;
            din    <= s_ula;
         end
         if (r_state == S_RDCAP) result <= outpilha;

         if (((r_state == S_PUSH) || (r_state == S_WB)) && (count < c_DEPTH))
            count <= count + 4'd1;
         else if (((r_state == S_POP1) || (r_state == S_POP2) ||
                   (r_state == S_RDCAP)) && (count != 4'd0))
            count <= count - 4'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_controle_pilha.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_pilha
// Description : Self-checking bench for controle_pilha with a behavioural
//               stack/ALU datapath and a scoreboard of expected completions.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_pilha;

   logic       clk = 1'b0;
   logic       rstn;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_op;
   logic [7:0] cmd_data;
   logic [4:0] cmd_opcode;
   logic       push, pop, load;
   logic [7:0] din;
   logic [4:0] opcode;
   logic [7:0] s_ula;
   logic       carryout;
   logic [7:0] outpilha;
   logic [7:0] result;
   logic       carry, done, err;
   logic [3:0] count;

   always #5 clk = ~clk;

   controle_pilha #(.DEPTH(8)) dut (
      .clk(clk), .rstn(rstn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_opcode(cmd_opcode),
      .push(push), .pop(pop), .load(load), .din(din), .opcode(opcode),
      .s_ula(s_ula), .carryout(carryout), .outpilha(outpilha),
      .result(result), .carry(carry), .done(done), .err(err), .count(count)
   );

   // Datapath model: registered top-of-stack, two operand registers, ALU.
   logic [7:0] stk [0:15];
   int         sp;
   logic [7:0] tos, opa, opb;
   logic       ld_sel;

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sp <= 0; tos <= 8'd0; opa <= 8'd0; opb <= 8'd0; ld_sel <= 1'b0;
      end else begin
         if (push && sp < 16) begin stk[sp] <= din; sp <= sp + 1; end
         if (pop && sp > 0) begin tos <= stk[sp-1]; sp <= sp - 1; end
         if (load) begin
            if (!ld_sel) opa <= tos; else opb <= tos;
            ld_sel <= ~ld_sel;
         end
      end
   end

   always_comb begin
      if (opcode == 5'b00100) {carryout, s_ula} = {1'b0, opa} + {1'b0, opb};
      else                    {carryout, s_ula} = {1'b0, opa} - {1'b0, opb};
   end
   assign outpilha = tos;

   typedef struct {
      logic [1:0]  op;
      logic [7:0]  data;
      logic [4:0]  opc;
      bit          noise;
      logic        e_err;
      logic [7:0]  e_result;
      logic        e_carry;
      logic [3:0]  e_count;
      int          e_lat;
      logic [23:0] e_trace;
      bit          chk_din;
      logic [7:0]  e_din;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;

   localparam logic [23:0] c_TR_PUSH = 24'h000020;
   localparam logic [23:0] c_TR_POP  = 24'h000080;
   localparam logic [23:0] c_TR_EXEC = 24'h442220;

   function automatic vec_t mk(input logic [1:0] op, input logic [7:0] data,
                               input logic [4:0] opc, input bit noise,
                               input logic e_err, input logic [7:0] e_res,
                               input logic e_c, input logic [3:0] e_cnt,
                               input int e_lat, input logic [23:0] e_tr,
                               input bit chk_din, input logic [7:0] e_din);
      vec_t v;
      v.op = op; v.data = data; v.opc = opc; v.noise = noise;
      v.e_err = e_err; v.e_result = e_res; v.e_carry = e_c; v.e_count = e_cnt;
      v.e_lat = e_lat; v.e_trace = e_tr; v.chk_din = chk_din; v.e_din = e_din;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Drive one command, then watch each following cycle until done.
   task automatic apply(input vec_t v);
      int          cyc;
      bit          got;
      logic [23:0] trace;
      logic [7:0]  seen_din;
      vec_t        e;
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data; cmd_opcode = v.opc;
      exp_q.push_back(v);
      @(posedge clk); #1;
      if (v.noise) begin
         cmd_op = 2'b01; cmd_data = 8'd55;
      end else cmd_valid = 1'b0;
      cyc = 0; got = 1'b0; trace = 24'd0; seen_din = 8'd0;
      while (!got && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (cyc == 5) cmd_valid = 1'b0;
         trace = {trace[20:0], push, pop, load};
         if (push) seen_din = din;
         chk("strobe_onehot", 32'({1'b0, push} + {1'b0, pop} + {1'b0, load}) > 1, 0);
         if (done) begin
            got = 1'b1;
            if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
            else begin
               e = exp_q.pop_front();
               chk("err",     err,     e.e_err);
               chk("result",  result,  e.e_result);
               chk("carry",   carry,   e.e_carry);
               chk("count",   count,   e.e_count);
               chk("latency", cyc,     e.e_lat);
               chk("strobes", trace,   e.e_trace);
               if (e.chk_din) chk("din", seen_din, e.e_din);
               if (e.op == 2'b11) chk("opcode", opcode, e.opc);
            end
         end
      end
      if (!got) begin
         chk("done_timeout", 1, 0);
         exp_q.delete();
      end
   endtask

   initial begin
      int   t;
      bit   bad;
      rstn = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 8'd0; cmd_opcode = 5'd0;

      // Vector table: running expected state is worked out by hand.
      tbl.push_back(mk(2'b00, 8'd0,  5'd0, 0, 0, 8'd0,  0, 4'd0, 1, 24'd0,     0, 8'd0));
      tbl.push_back(mk(2'b10, 8'd0,  5'd0, 0, 1, 8'd0,  0, 4'd0, 1, 24'd0,     0, 8'd0));
      tbl.push_back(mk(2'b01, 8'd12, 5'd0, 0, 0, 8'd0,  0, 4'd1, 2, c_TR_PUSH, 1, 8'd12));
      tbl.push_back(mk(2'b01, 8'd15, 5'd0, 0, 0, 8'd0,  0, 4'd2, 2, c_TR_PUSH, 1, 8'd15));
      tbl.push_back(mk(2'b11, 8'd0,  5'b00100, 1, 0, 8'd27, 0, 4'd1, 8, c_TR_EXEC, 1, 8'd27));
      tbl.push_back(mk(2'b11, 8'd0,  5'b00100, 0, 1, 8'd27, 0, 4'd1, 1, 24'd0,     0, 8'd0));
      tbl.push_back(mk(2'b10, 8'd0,  5'd0, 0, 0, 8'd27, 0, 4'd0, 3, c_TR_POP,  0, 8'd0));
      tbl.push_back(mk(2'b01, 8'd7,  5'd0, 0, 0, 8'd27, 0, 4'd1, 2, c_TR_PUSH, 1, 8'd7));
      tbl.push_back(mk(2'b10, 8'd0,  5'd0, 0, 0, 8'd7,  0, 4'd0, 3, c_TR_POP,  0, 8'd0));
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(2'b01, 8'hA0 + 8'(i), 5'd0, 0, 0, 8'd7, 0, 4'(i + 1), 2,
                          c_TR_PUSH, 1, 8'hA0 + 8'(i)));
      tbl.push_back(mk(2'b01, 8'd99, 5'd0, 0, 1, 8'd7,  0, 4'd8, 1, 24'd0,     0, 8'd0));
      tbl.push_back(mk(2'b11, 8'd0,  5'b00100, 0, 0, 8'h4D, 1, 4'd7, 8, c_TR_EXEC, 1, 8'h4D));
      tbl.push_back(mk(2'b10, 8'd0,  5'd0, 0, 0, 8'h4D, 1, 4'd6, 3, c_TR_POP,  0, 8'd0));
      tbl.push_back(mk(2'b11, 8'd0,  5'b00001, 0, 0, 8'h01, 0, 4'd5, 8, c_TR_EXEC, 1, 8'h01));

      // Reset state, held and then released.
      repeat (2) @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_strobes", {push, pop, load, done, err}, 0);
      chk("rst_result", {result, carry, din, opcode}, 0);
      rstn = 1'b1;
      @(negedge clk);
      chk("rst_ready", cmd_ready, 1);

      foreach (tbl[i]) apply(tbl[i]);

      // Reset asserted during LOAD1 of an EXEC aborts it.
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = 2'b11; cmd_opcode = 5'b00100;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      t = 0;
      while (!load && t < 10) begin @(negedge clk); t++; end
      chk("abort_reached_load", load, 1);
      #1 rstn = 1'b0;
      #1;
      chk("abort_strobes", {push, pop, load}, 0);
      chk("abort_count", count, 0);
      chk("abort_done", {done, err}, 0);
      chk("abort_regs", {result, carry, din, opcode}, 0);
      chk("abort_ready", cmd_ready, 1);
      @(negedge clk);
      rstn = 1'b1;
      bad = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (push || pop || load || done || err) bad = 1'b1;
      end
      chk("abort_quiet", bad, 0);

      // Normal operation resumes after the abort.
      apply(mk(2'b01, 8'd5, 5'd0, 0, 0, 8'd0, 0, 4'd1, 2, c_TR_PUSH, 1, 8'd5));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
